// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: pointer sync, memory read issue, 2-entry output buffer.
// Optional macro RD_PTR_ERR_EN enables the sticky ptr_err pointer-corruption detector.
module async_fifo_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  ptr_err
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         wr_sync_bin;
  logic [PW-1:0]         rd_ptr_bin_q;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         rd_ptr_gray_q;
  logic [PW-1:0]         avail;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;
  logic                  pop;
  logic [2:0]            level;

  // Write-pointer synchroniser chain
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits
  always_comb begin
    wr_sync_bin = '0;
    for (int i = 0; i < int'(PW); i++) wr_sync_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end

  assign avail      = wr_sync_bin - rd_ptr_bin_q;
  assign rd_ptr_nxt = rd_ptr_bin_q + PW'(1);
  assign pop        = m_valid & m_ready;
  assign level      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  // Only issue when the word returning next cycle is guaranteed a buffer slot
  assign mem_rd_en  = (avail != '0) && (level < 3'd2);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (mem_rd_en) begin
        rd_ptr_bin_q  <= rd_ptr_nxt;
        rd_ptr_gray_q <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      end
    end
  end

  // Output buffer next state: head is the presented word, tail the second entry
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = mem_dout;
        else               tail_d = mem_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = mem_dout;
        end else begin
          head_d = tail_q;
          tail_d = mem_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef RD_PTR_ERR_EN
  logic ptr_err_q;

  // More than a full memory of unread words can only come from a corrupt pointer
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)                ptr_err_q <= 1'b0;
    else if (avail > PW'(DEPTH)) ptr_err_q <= 1'b1;
  end

  assign ptr_err = ptr_err_q;
`else
  assign ptr_err = 1'b0;
`endif

  assign rd_ptr_gray = rd_ptr_gray_q;
  assign mem_rd_addr = rd_ptr_bin_q[ADDR_WIDTH-1:0];
  assign m_valid     = (occ_q != 2'd0);
  assign empty       = (occ_q == 2'd0);
  assign m_data      = head_q;
  assign rd_count    = avail;

endmodule
